spi_mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single SPI SRAM memory controller between the Neander CPU (port 0) and the program loader/debug port (port 1).
- Selects one requester, issues a single-cycle request to the controller and holds the address/data stable until the controller's ready pulse.
- Returns read data and a one-cycle ready to the winning port.
- Sits between the CPU/loader and the SPI memory controller, in the same clock and reset domain.

---
 rtl/spi_mem_arbiter_if.sv | 42 ++++
 rtl/spi_mem_arbiter.sv | 116 +++++++++++
 tb/tb_spi_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_arbiter_if.sv
// Bundle of requester, status and memory-controller signals shared by the
// SPI memory arbiter and its environment.
interface spi_mem_arbiter_if;
    logic       p0_req;
    logic       p0_we;
    logic [7:0] p0_addr;
    logic [7:0] p0_wdata;
    logic       p0_ready;
    logic       p1_req;
    logic       p1_we;
    logic [7:0] p1_addr;
    logic [7:0] p1_wdata;
    logic       p1_lock;
    logic       p1_ready;
    logic [7:0] rdata;
    logic       busy;
    logic       grant;
    logic       mc_req;
    logic       mc_we;
    logic [7:0] mc_addr;
    logic [7:0] mc_wdata;
    logic [7:0] mc_rdata;
    logic       mc_ready;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        input  mc_rdata, mc_ready,
        output p0_ready, p1_ready, rdata, busy, grant,
        output mc_req, mc_we, mc_addr, mc_wdata
    );

    // Requesters plus controller side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        output mc_rdata, mc_ready,
        input  p0_ready, p1_ready, rdata, busy, grant,
        input  mc_req, mc_we, mc_addr, mc_wdata
    );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter in front of the SPI SRAM controller: CPU on port 0,
// loader/debug on port 1, one outstanding controller transaction at a time.
module spi_mem_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    spi_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state_r;
    logic       mc_req_r;
    logic       mc_we_r;
    logic [7:0] mc_addr_r;
    logic [7:0] mc_wdata_r;
    logic [7:0] rdata_r;
    logic       p0_ready_r;
    logic       p1_ready_r;
    logic       busy_r;
    logic       grant_r;

    logic       p0_elig_s;
    logic       p1_elig_s;
    logic       win_valid_s;
    logic       win_port_s;

    assign bus.mc_req   = mc_req_r;
    assign bus.mc_we    = mc_we_r;
    assign bus.mc_addr  = mc_addr_r;
    assign bus.mc_wdata = mc_wdata_r;
    assign bus.rdata    = rdata_r;
    assign bus.p0_ready = p0_ready_r;
    assign bus.p1_ready = p1_ready_r;
    assign bus.busy     = busy_r;
    assign bus.grant    = grant_r;

    // Pick the next owner; lock shuts port 0 out even when port 1 is idle
    always_comb begin
        p0_elig_s   = bus.p0_req & ~bus.p1_lock;
        p1_elig_s   = bus.p1_req;
        win_valid_s = p0_elig_s | p1_elig_s;
        if (p0_elig_s && p1_elig_s) begin
            win_port_s = ROUND_ROBIN ? ~grant_r : 1'b0;
        end else if (p1_elig_s) begin
            win_port_s = 1'b1;
        end else begin
            win_port_s = 1'b0;
        end
    end

    // Transaction sequencer with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            mc_req_r   <= 1'b0;
            mc_we_r    <= 1'b0;
            mc_addr_r  <= 8'h00;
            mc_wdata_r <= 8'h00;
            rdata_r    <= 8'h00;
            p0_ready_r <= 1'b0;
            p1_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            grant_r    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        grant_r    <= win_port_s;
                        mc_we_r    <= win_port_s ? bus.p1_we    : bus.p0_we;
                        mc_addr_r  <= win_port_s ? bus.p1_addr  : bus.p0_addr;
                        mc_wdata_r <= win_port_s ? bus.p1_wdata : bus.p0_wdata;
                        mc_req_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mc_req_r <= 1'b0;
                    state_r  <= WAIT;
                end
                WAIT: begin
                    if (bus.mc_ready) begin
                        // Writes leave the last read value visible
                        if (!mc_we_r) begin
                            rdata_r <= bus.mc_rdata;
                        end
                        p0_ready_r <= ~grant_r;
                        p1_ready_r <= grant_r;
                        state_r    <= RESP;
                    end
                end
                RESP: begin
                    p0_ready_r <= 1'b0;
                    p1_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    mc_req_r   <= 1'b0;
                    p0_ready_r <= 1'b0;
                    p1_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: a round-robin and a fixed-priority
// instance, each behind a one-cycle-latency controller model (rdata = addr ^ 0x4A).
module tb_spi_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    spi_mem_arbiter_if if_rr ();
    spi_mem_arbiter_if if_fp ();

    spi_mem_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (.clk(clk), .reset(reset), .bus(if_rr.slave));
    spi_mem_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (.clk(clk), .reset(reset), .bus(if_fp.slave));

    always #5 clk = ~clk;

    logic       rr_pend, rr_m_ready, fp_pend, fp_m_ready;
    logic [7:0] rr_m_rdata, fp_m_rdata;
    logic       spur_ready = 1'b0;
    logic [7:0] spur_rdata = 8'h00;

    assign if_rr.mc_ready = rr_m_ready | spur_ready;
    assign if_rr.mc_rdata = spur_ready ? spur_rdata : rr_m_rdata;
    assign if_fp.mc_ready = fp_m_ready;
    assign if_fp.mc_rdata = fp_m_rdata;

    // Controller model: ready two edges after the request pulse
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_pend <= 1'b0; rr_m_ready <= 1'b0; rr_m_rdata <= 8'h00;
            fp_pend <= 1'b0; fp_m_ready <= 1'b0; fp_m_rdata <= 8'h00;
        end else begin
            rr_pend    <= if_rr.mc_req;
            rr_m_ready <= rr_pend;
            if (rr_pend) rr_m_rdata <= if_rr.mc_addr ^ 8'h4A;
            fp_pend    <= if_fp.mc_req;
            fp_m_ready <= fp_pend;
            if (fp_pend) fp_m_rdata <= if_fp.mc_addr ^ 8'h4A;
        end
    end

    int         mon_req_n, mon_req_idx, mon_mcr_idx, mon_rdy_idx, mon_other;
    logic       mon_we, mon_stable;
    logic [7:0] mon_addr, mon_wdata;
    logic [7:0] seq_addr [4];
    logic       seq_grant [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follow one round-robin-instance transaction until the given port's ready
    task automatic monitor(input logic port);
        mon_req_n = 0; mon_req_idx = -1; mon_mcr_idx = -1; mon_rdy_idx = -1;
        mon_other = 0; mon_stable = 1'b1;
        for (int i = 0; i < 30 && mon_rdy_idx < 0; i++) begin
            @(negedge clk);
            if (if_rr.mc_req) begin
                mon_req_n++; mon_req_idx = i;
                mon_addr = if_rr.mc_addr; mon_we = if_rr.mc_we; mon_wdata = if_rr.mc_wdata;
            end else if (mon_req_idx >= 0 && mon_mcr_idx < 0) begin
                if (if_rr.mc_addr !== mon_addr || if_rr.mc_we !== mon_we || if_rr.mc_wdata !== mon_wdata)
                    mon_stable = 1'b0;
            end
            if (if_rr.mc_ready && mon_req_idx >= 0 && mon_mcr_idx < 0) mon_mcr_idx = i;
            if (port ? if_rr.p1_ready : if_rr.p0_ready) mon_rdy_idx = i;
            if (port ? if_rr.p0_ready : if_rr.p1_ready) mon_other++;
        end
    endtask

    task automatic collect(input bit fp);
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            seq_addr[k] = 8'hFF; seq_grant[k] = 1'bx;
        end
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (fp ? if_fp.mc_req : if_rr.mc_req) begin
                seq_addr[n]  = fp ? if_fp.mc_addr : if_rr.mc_addr;
                seq_grant[n] = fp ? if_fp.grant : if_rr.grant;
                n++;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        int rdy_cnt;
        if_rr.p0_req = 1'b0; if_rr.p0_we = 1'b0; if_rr.p0_addr = 8'h00; if_rr.p0_wdata = 8'h00;
        if_rr.p1_req = 1'b0; if_rr.p1_we = 1'b0; if_rr.p1_addr = 8'h00; if_rr.p1_wdata = 8'h00;
        if_rr.p1_lock = 1'b0;
        if_fp.p0_req = 1'b0; if_fp.p0_we = 1'b0; if_fp.p0_addr = 8'h00; if_fp.p0_wdata = 8'h00;
        if_fp.p1_req = 1'b0; if_fp.p1_we = 1'b0; if_fp.p1_addr = 8'h00; if_fp.p1_wdata = 8'h00;
        if_fp.p1_lock = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_busy",   32'(if_rr.busy),    32'h0);
        chk("rst_mc_req", 32'(if_rr.mc_req),  32'h0);
        chk("rst_grant",  32'(if_rr.grant),   32'h1);
        chk("rst_rdata",  32'(if_rr.rdata),   32'h00);
        chk("rst_addr",   32'(if_rr.mc_addr), 32'h00);
        chk("rst_ready",  32'({if_rr.p0_ready, if_rr.p1_ready}), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Single read on port 0
        @(posedge clk); #1 if_rr.p0_req = 1'b1; if_rr.p0_we = 1'b0; if_rr.p0_addr = 8'h10;
        monitor(1'b0);
        @(posedge clk); #1 if_rr.p0_req = 1'b0;
        @(negedge clk);
        chk("rd_req_count", 32'(mon_req_n),   32'd1);
        chk("rd_req_lat",   32'(mon_req_idx), 32'd1);
        chk("rd_addr",      32'(mon_addr),    32'h10);
        chk("rd_we",        32'(mon_we),      32'h0);
        chk("rd_rdy_lat",   32'(mon_rdy_idx), 32'(mon_mcr_idx + 1));
        chk("rd_mcr_idx",   32'(mon_mcr_idx), 32'd3);
        chk("rd_other",     32'(mon_other),   32'd0);
        chk("rd_rdata",     32'(if_rr.rdata), 32'h5A);

        // Write on port 1 keeps rdata
        @(posedge clk); #1 if_rr.p1_req = 1'b1; if_rr.p1_we = 1'b1; if_rr.p1_addr = 8'h80; if_rr.p1_wdata = 8'h3C;
        monitor(1'b1);
        @(posedge clk); #1 if_rr.p1_req = 1'b0; if_rr.p1_we = 1'b0;
        @(negedge clk);
        chk("wr_we",     32'(mon_we),      32'h1);
        chk("wr_addr",   32'(mon_addr),    32'h80);
        chk("wr_wdata",  32'(mon_wdata),   32'h3C);
        chk("wr_stable", 32'(mon_stable),  32'h1);
        chk("wr_ready",  32'(mon_rdy_idx), 32'd4);
        chk("wr_other",  32'(mon_other),   32'd0);
        chk("wr_rdata",  32'(if_rr.rdata), 32'h5A);
        chk("wr_grant",  32'(if_rr.grant), 32'h1);

        // Round-robin contention from reset
        @(posedge clk); #1 reset = 1'b1;
        if_rr.p0_req = 1'b1; if_rr.p0_addr = 8'h01; if_rr.p1_req = 1'b1; if_rr.p1_addr = 8'h02;
        @(posedge clk); #1 reset = 1'b0;
        collect(1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_addr%0d", k),  32'(seq_addr[k]),  (k % 2 == 0) ? 32'h01 : 32'h02);
            chk($sformatf("rr_grant%0d", k), 32'(seq_grant[k]), 32'(k % 2));
        end
        @(posedge clk); #1 if_rr.p0_req = 1'b0; if_rr.p1_req = 1'b0;

        // Fixed priority: port 0 served every time
        @(posedge clk); #1 reset = 1'b1;
        if_fp.p0_req = 1'b1; if_fp.p0_addr = 8'h01; if_fp.p1_req = 1'b1; if_fp.p1_addr = 8'h02;
        @(posedge clk); #1 reset = 1'b0;
        collect(1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fp_addr%0d", k),  32'(seq_addr[k]),  32'h01);
            chk($sformatf("fp_grant%0d", k), 32'(seq_grant[k]), 32'h0);
        end
        @(posedge clk); #1 if_fp.p0_req = 1'b0; if_fp.p1_req = 1'b0;
        pulse_reset();

        // Lock blocks port 0 while port 1 is idle
        @(posedge clk); #1 if_rr.p1_lock = 1'b1; if_rr.p0_req = 1'b1; if_rr.p0_addr = 8'h33;
        rdy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_rr.mc_req || if_rr.busy) rdy_cnt++;
        end
        chk("lock_no_req", 32'(rdy_cnt), 32'd0);
        @(posedge clk); #1 if_rr.p1_lock = 1'b0;
        monitor(1'b0);
        @(posedge clk); #1 if_rr.p0_req = 1'b0;
        @(negedge clk);
        chk("unlock_lat",   32'(mon_req_idx), 32'd1);
        chk("unlock_addr",  32'(mon_addr),    32'h33);
        chk("unlock_ready", 32'(mon_rdy_idx), 32'd4);
        chk("unlock_rdata", 32'(if_rr.rdata), 32'h79);

        // Reset during WAIT
        @(posedge clk); #1 if_rr.p0_req = 1'b1; if_rr.p0_addr = 8'h20;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("mid_busy", 32'(if_rr.busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_busy",   32'(if_rr.busy),   32'h0);
        chk("mr_mc_req", 32'(if_rr.mc_req), 32'h0);
        chk("mr_rdata",  32'(if_rr.rdata),  32'h00);
        chk("mr_grant",  32'(if_rr.grant),  32'h1);
        if_rr.p0_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        rdy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_rr.p0_ready || if_rr.p1_ready) rdy_cnt++;
        end
        chk("mr_no_ready", 32'(rdy_cnt), 32'd0);
        @(posedge clk); #1 if_rr.p0_req = 1'b1; if_rr.p0_addr = 8'h44;
        monitor(1'b0);
        @(posedge clk); #1 if_rr.p0_req = 1'b0;
        @(negedge clk);
        chk("mr_after_ready", 32'(mon_rdy_idx), 32'd4);
        chk("mr_after_rdata", 32'(if_rr.rdata), 32'h0E);

        // Spurious controller ready while idle
        @(posedge clk); #1 spur_rdata = 8'hEE; spur_ready = 1'b1;
        @(posedge clk); #1 spur_ready = 1'b0;
        rdy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_rr.p0_ready || if_rr.p1_ready || if_rr.busy) rdy_cnt++;
        end
        chk("spur_no_ready", 32'(rdy_cnt),     32'd0);
        chk("spur_rdata",    32'(if_rr.rdata), 32'h0E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
